// File: rtl/noc_pe_receiver.sv
// Per-node NoC traffic sink: dst/type check, per-flit latency, min/max/sum stats, finish and retransmit-request reporting.
// Latency: flit captured on the transfer edge, stats/flags updated one edge later. Backpressure: in_ready only (high in RUN/DONE).
// Optional RX_PARITY_CHK_EN: data[21] is checked as even parity over data[20:2]; a failure counts as misdelivered.
module noc_pe_receiver #(
    parameter logic [3:0] NODE_ID = 4'h0,
    parameter int         TIME_W  = 10,
    parameter int         SUM_W   = 28,
    parameter int         CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic [CNT_W-1:0]  receive_num,
    input  logic [TIME_W-1:0] cur_time,
    input  logic [39:0]       in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              task_receive_finish_flag,
    output logic [TIME_W-1:0] latency_min,
    output logic [TIME_W-1:0] latency_max,
    output logic [SUM_W-1:0]  latency_sum,
    output logic              so_retrsreq_receive_flag,
    output logic [7:0]        so_retrsreq_receive_num
);

    typedef struct packed {
        logic [3:0]        src;
        logic [3:0]        dst;
        logic [TIME_W-1:0] ts;
        logic [19:0]       data;
        logic [1:0]        typ;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_cap_vld;
    logic [TIME_W-1:0] r_cap_lat;
    logic              r_cap_bad;

    logic [TIME_W-1:0] r_min;
    logic [TIME_W-1:0] r_max;
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic              r_retrs_flag;
    logic [7:0]        r_retrs_num;

    flit_t             w_flit;
    logic              w_xfer;
    logic [TIME_W-1:0] w_lat;
    logic              w_par_err;
    logic              w_bad;
    logic              w_upd;
    logic              w_good;
    logic              w_misd;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_last;
    logic [SUM_W:0]    w_sum_ext;
    logic              w_unused;

    assign w_flit = in_flit;
    assign w_xfer = in_valid & in_ready;
    // Modular subtraction makes the timestamp wrap of the free-running clock harmless.
    assign w_lat  = cur_time - w_flit.ts;

`ifdef RX_PARITY_CHK_EN
    assign w_par_err = ^w_flit.data;
    assign w_unused  = ^{w_flit.src, w_flit.typ[0]};
`else
    assign w_par_err = 1'b0;
    assign w_unused  = ^{w_flit.src, w_flit.typ[0], w_flit.data};
`endif

    // Types 2'b10/2'b11 are not deliverable traffic and go down the retransmit path.
    assign w_bad     = (w_flit.dst != NODE_ID) | w_flit.typ[1] | w_par_err;

    assign w_upd     = r_cap_vld & (r_state == ST_RUN);
    assign w_good    = w_upd & ~r_cap_bad;
    assign w_misd    = w_upd & r_cap_bad;
    assign w_cnt_nxt = r_rx_cnt + 1'b1;
    assign w_last    = w_good & (w_cnt_nxt == receive_num);
    assign w_sum_ext = {1'b0, r_sum} + {{(SUM_W + 1 - TIME_W){1'b0}}, r_cap_lat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        w_state_nxt = (receive_num == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld    <= 1'b0;
            r_cap_lat    <= '0;
            r_cap_bad    <= 1'b0;
            r_min        <= '1;
            r_max        <= '0;
            r_sum        <= '0;
            r_rx_cnt     <= '0;
            r_retrs_flag <= 1'b0;
            r_retrs_num  <= '0;
        end else if (flush) begin
            // A flit arriving together with flush is dropped: the capture stage clears here.
            r_cap_vld    <= 1'b0;
            r_cap_lat    <= '0;
            r_cap_bad    <= 1'b0;
            r_min        <= '1;
            r_max        <= '0;
            r_sum        <= '0;
            r_rx_cnt     <= '0;
            r_retrs_flag <= 1'b0;
            r_retrs_num  <= '0;
        end else begin
            r_cap_vld    <= w_xfer & (r_state == ST_RUN);
            r_cap_lat    <= w_lat;
            r_cap_bad    <= w_bad;
            r_retrs_flag <= w_misd;
            if (w_misd && (r_retrs_num != 8'hFF)) begin
                r_retrs_num <= r_retrs_num + 8'd1;
            end
            if (w_good) begin
                r_rx_cnt <= w_cnt_nxt;
                if (r_cap_lat < r_min) begin
                    r_min <= r_cap_lat;
                end
                if (r_cap_lat > r_max) begin
                    r_max <= r_cap_lat;
                end
                r_sum <= w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
            end
        end
    end

    assign in_ready                 = (r_state != ST_IDLE);
    assign task_receive_finish_flag = (r_state == ST_DONE);
    assign latency_min              = r_min;
    assign latency_max              = r_max;
    assign latency_sum              = r_sum;
    assign so_retrsreq_receive_flag = r_retrs_flag;
    assign so_retrsreq_receive_num  = r_retrs_num;

endmodule
